dispatch_queue_unit: RTL and testbench
======================================

// Module: dispatch_queue_unit
// PURPOSE
//  Buffered, parametrised dispatcher between decoder/ifetch and ROB, RS and LSB.
//  Decoded instructions enter an IQ_DEPTH-entry FIFO through a valid/ready handshake.
//  The head entry is renamed and its operands are resolved from RF, ROB and NUM_CDB
//  result buses. It then issues in one registered cycle to RS or LSB, plus ROB and RF rename.
// PARAMETERS
//  XLEN      32  data and pc width
//  ROB_W     4   ROB alias width; alias 0 = "no dependency"
//  OPT_W     6   instruction-type code width
//  IQ_DEPTH  4   FIFO entries; power of two, >=2
//  NUM_CDB   2   result-bus channels (ALU, LSB, ...); lower index = higher priority
// PORTS
//  clk            in   1              clock, rising edge
//  rst_n          in   1              asynchronous, active-low reset
//  rdy            in   1              global enable; low freezes all state
//  rollback       in   1              mispredict flush
//  in_valid/in_ready  in/out 1        decoder handshake; in_ready = ~full
//  in_pc,in_imm   in   XLEN           predicted pc, immediate
//  in_type        in   OPT_W          instruction type
//  in_rd,in_rs1,in_rs2 in 5           register indices
//  in_is_ls,in_is_btype,in_pred_jump in 1 class flags, prediction
//  rob_full,rs_full,lsb_full in 1     downstream back-pressure
//  rob_alias      in   ROB_W          alias the ROB allocates next
//  rs1_to_rf,rs2_to_rf out 5          head rs1/rs2 (combinational)
//  rf_Vi,rf_Vj    in   XLEN           RF values
//  rf_Qi,rf_Qj    in   ROB_W          RF rename tags
//  Qi_to_rob,Qj_to_rob out ROB_W      = rf_Qi/rf_Qj (combinational ROB lookup)
//  rob_Vi_ok,rob_Vj_ok in 1; rob_Vi,rob_Vj in XLEN   ROB-ready values
//  cdb_valid      in   NUM_CDB        per-channel result valid
//  cdb_alias      in   NUM_CDB*ROB_W  packed aliases, channel k at [k*ROB_W +: ROB_W]
//  cdb_data       in   NUM_CDB*XLEN   packed results
//  rob_issue,rs_issue,lsb_issue out 1 one-cycle issue strobes
//  out_alias out ROB_W; out_type out OPT_W; out_rd out 5; out_pc,out_imm out XLEN
//  out_Vi,out_Vj  out  XLEN; out_Qi,out_Qj out ROB_W   resolved operands
//  out_is_ls,out_is_btype,out_pred_jump out 1
//  ren_valid out 1; ren_reg out 5; ren_alias out ROB_W   RF rename write
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO pointers and count = 0; every output register = 0.
//    in_ready = 1 after reset.
//  Push: in_valid & in_ready & rdy & ~rollback. in_ready = (count != IQ_DEPTH),
//    from registered count only. A full FIFO rejects push even when it pops in the same cycle.
//  Issue condition: count!=0 & rdy & ~rollback & ~rob_full & (head.is_ls ? ~lsb_full : ~rs_full).
//    On issue, pop the head and register outputs next edge.
//    rob_issue=1 always. lsb_issue=is_ls, rs_issue=~is_ls. ren_valid=(rd!=0).
//    out_alias=ren_alias=rob_alias. Without issue, all strobes = 0 next cycle; payload holds.
//  Latency: an entry pushed at edge t is at the head after t. It issues at edge t+1
//    at the earliest; strobes are visible after t+1. No input->output bypass.
//  Operand resolution, per source, when Q=rf_Q:
//    Q==0 -> (rf_V,0).
//    Else the lowest k with cdb_valid[k] & cdb_alias[k]==Q -> (cdb_data[k],0).
//    Else rob_V_ok -> (rob_V,0).
//    Else (rf_V,Q).
//  Pointers wrap modulo IQ_DEPTH; count is IQ_DEPTH's width+1 bits.
//  Simultaneous push+pop: count unchanged; both pointers advance.
//  rollback=1: next edge count=0, pointers=0, all strobes 0; overrides push and issue.
//  rdy=0: no state or output register changes. Downstream is also gated by rdy.
//  Reset mid-operation discards FIFO contents immediately (asynchronous).
// TESTING
//  1. Reset, push addi rd=5 rs1=0 imm=7 at cycle 0 -> cycle 2: rs_issue=1, rob_issue=1,
//     out_Vi=0, out_Qi=0, ren_reg=5, ren_alias=rob_alias; lsb_issue=0.
//  2. rf_Qi=3, cdb_valid=2'b11, cdb_alias={3,3}, cdb_data={0xBB,0xAA} at issue
//     -> out_Vi=0xAA (channel 0 wins), out_Qi=0. With no CDB match and rob_Vi_ok=0
//     -> out_Qi=3.
//  3. Push 4 entries with rob_full=1 -> in_ready=0 after the 4th push, 5th ignored.
//     Release rob_full -> 4 consecutive issue cycles in FIFO order, then in_ready=1.
//  4. Head is a load with lsb_full=1, rs_full=0 -> no issue and head holds.
//     lsb_full=0 -> lsb_issue=1, rs_issue=0.
//  5. Hold 3 entries, assert rollback together with in_valid -> next cycle count=0,
//     all strobes 0, pushed entry discarded.
//  6. rdy=0 for 3 cycles mid-stream -> outputs and count frozen; sequence resumes
//     unchanged; rst_n pulsed low mid-stream -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/dispatch_queue_unit.sv
// Instruction queue + dispatcher: buffers decoded ops, renames the head and issues it to RS/LSB/ROB.
// Issue is registered one edge after the head is ready; in_ready drops when full, downstream fulls stall the head.
module dispatch_queue_unit #(
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int OPT_W    = 6,
  parameter int IQ_DEPTH = 4,
  parameter int NUM_CDB  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [OPT_W-1:0]         in_type,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic                     in_is_ls,
  input  logic                     in_is_btype,
  input  logic                     in_pred_jump,
  input  logic                     rob_full,
  input  logic                     rs_full,
  input  logic                     lsb_full,
  input  logic [ROB_W-1:0]         rob_alias,
  output logic [4:0]               rs1_to_rf,
  output logic [4:0]               rs2_to_rf,
  input  logic [XLEN-1:0]          rf_Vi,
  input  logic [XLEN-1:0]          rf_Vj,
  input  logic [ROB_W-1:0]         rf_Qi,
  input  logic [ROB_W-1:0]         rf_Qj,
  output logic [ROB_W-1:0]         Qi_to_rob,
  output logic [ROB_W-1:0]         Qj_to_rob,
  input  logic                     rob_Vi_ok,
  input  logic                     rob_Vj_ok,
  input  logic [XLEN-1:0]          rob_Vi,
  input  logic [XLEN-1:0]          rob_Vj,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_alias,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     rob_issue,
  output logic                     rs_issue,
  output logic                     lsb_issue,
  output logic [ROB_W-1:0]         out_alias,
  output logic [OPT_W-1:0]         out_type,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_Vi,
  output logic [XLEN-1:0]          out_Vj,
  output logic [ROB_W-1:0]         out_Qi,
  output logic [ROB_W-1:0]         out_Qj,
  output logic                     out_is_ls,
  output logic                     out_is_btype,
  output logic                     out_pred_jump,
  output logic                     ren_valid,
  output logic [4:0]               ren_reg,
  output logic [ROB_W-1:0]         ren_alias
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [OPT_W-1:0] typ;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             is_ls;
    logic             is_btype;
    logic             pred_jump;
  } iq_ent_t;

  iq_ent_t          r_mem [IQ_DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  iq_ent_t                 w_head;
  iq_ent_t                 w_in_ent;
  logic                    w_push;
  logic                    w_pop;
  logic [XLEN+ROB_W-1:0]   w_res_i;
  logic [XLEN+ROB_W-1:0]   w_res_j;

  // Returns {value, tag}; tag==0 means the operand is ready.
  function automatic logic [XLEN+ROB_W-1:0] resolve(
    input logic [ROB_W-1:0] q,
    input logic [XLEN-1:0]  rf_v,
    input logic             rob_ok,
    input logic [XLEN-1:0]  rob_v
  );
    logic                  hit;
    logic [XLEN+ROB_W-1:0] res;
    hit = 1'b0;
    res = {rf_v, q};
    if (q == '0) begin
      res = {rf_v, {ROB_W{1'b0}}};
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (!hit && cdb_valid[k] && cdb_alias[k*ROB_W +: ROB_W] == q) begin
          res = {cdb_data[k*XLEN +: XLEN], {ROB_W{1'b0}}};
          hit = 1'b1;
        end
      end
      if (!hit && rob_ok) res = {rob_v, {ROB_W{1'b0}}};
    end
    return res;
  endfunction

  assign w_head    = r_mem[r_rptr];
  assign w_in_ent  = {in_pc, in_imm, in_type, in_rd, in_rs1, in_rs2,
                      in_is_ls, in_is_btype, in_pred_jump};
  assign in_ready  = (r_count != CNT_W'(IQ_DEPTH));
  assign rs1_to_rf = w_head.rs1;
  assign rs2_to_rf = w_head.rs2;
  assign Qi_to_rob = rf_Qi;
  assign Qj_to_rob = rf_Qj;
  assign w_res_i   = resolve(rf_Qi, rf_Vi, rob_Vi_ok, rob_Vi);
  assign w_res_j   = resolve(rf_Qj, rf_Vj, rob_Vj_ok, rob_Vj);

  assign w_push = in_valid & in_ready & rdy & ~rollback;
  assign w_pop  = (r_count != '0) & rdy & ~rollback & ~rob_full &
                  (w_head.is_ls ? ~lsb_full : ~rs_full);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_count       <= '0;
      rob_issue     <= 1'b0;
      rs_issue      <= 1'b0;
      lsb_issue     <= 1'b0;
      ren_valid     <= 1'b0;
      out_alias     <= '0;
      out_type      <= '0;
      out_rd        <= '0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_Vi        <= '0;
      out_Vj        <= '0;
      out_Qi        <= '0;
      out_Qj        <= '0;
      out_is_ls     <= 1'b0;
      out_is_btype  <= 1'b0;
      out_pred_jump <= 1'b0;
      ren_reg       <= '0;
      ren_alias     <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_rptr    <= '0;
        r_wptr    <= '0;
        r_count   <= '0;
        rob_issue <= 1'b0;
        rs_issue  <= 1'b0;
        lsb_issue <= 1'b0;
        ren_valid <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        rob_issue <= w_pop;
        rs_issue  <= w_pop & ~w_head.is_ls;
        lsb_issue <= w_pop & w_head.is_ls;
        ren_valid <= w_pop & (w_head.rd != 5'd0);
        // Payload only moves on issue so downstream can sample it late.
        if (w_pop) begin
          out_alias     <= rob_alias;
          out_type      <= w_head.typ;
          out_rd        <= w_head.rd;
          out_pc        <= w_head.pc;
          out_imm       <= w_head.imm;
          out_Vi        <= w_res_i[XLEN+ROB_W-1:ROB_W];
          out_Vj        <= w_res_j[XLEN+ROB_W-1:ROB_W];
          out_Qi        <= w_res_i[ROB_W-1:0];
          out_Qj        <= w_res_j[ROB_W-1:0];
          out_is_ls     <= w_head.is_ls;
          out_is_btype  <= w_head.is_btype;
          out_pred_jump <= w_head.pred_jump;
          ren_reg       <= w_head.rd;
          ren_alias     <= rob_alias;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue_unit.sv
// Directed plus randomized bench for dispatch_queue_unit against a queue-based reference model.
module tb_dispatch_queue_unit;
  localparam int XLEN = 32, ROB_W = 4, OPT_W = 6, DEPTH = 4, NC = 2;

  logic clk = 1'b0;
  logic rst_n, rdy, rollback, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [OPT_W-1:0] in_type;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic in_is_ls, in_is_btype, in_pred_jump;
  logic rob_full, rs_full, lsb_full;
  logic [ROB_W-1:0] rob_alias;
  logic [4:0] rs1_to_rf, rs2_to_rf;
  logic [XLEN-1:0] rf_Vi, rf_Vj, rob_Vi, rob_Vj;
  logic [ROB_W-1:0] rf_Qi, rf_Qj, Qi_to_rob, Qj_to_rob;
  logic rob_Vi_ok, rob_Vj_ok;
  logic [NC-1:0] cdb_valid;
  logic [NC*ROB_W-1:0] cdb_alias;
  logic [NC*XLEN-1:0] cdb_data;
  logic rob_issue, rs_issue, lsb_issue, ren_valid;
  logic [ROB_W-1:0] out_alias, out_Qi, out_Qj, ren_alias;
  logic [OPT_W-1:0] out_type;
  logic [4:0] out_rd, ren_reg;
  logic [XLEN-1:0] out_pc, out_imm, out_Vi, out_Vj;
  logic out_is_ls, out_is_btype, out_pred_jump;

  dispatch_queue_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .OPT_W(OPT_W), .IQ_DEPTH(DEPTH), .NUM_CDB(NC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_is_ls(in_is_ls), .in_is_btype(in_is_btype),
    .in_pred_jump(in_pred_jump), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_alias(rob_alias), .rs1_to_rf(rs1_to_rf), .rs2_to_rf(rs2_to_rf),
    .rf_Vi(rf_Vi), .rf_Vj(rf_Vj), .rf_Qi(rf_Qi), .rf_Qj(rf_Qj),
    .Qi_to_rob(Qi_to_rob), .Qj_to_rob(Qj_to_rob), .rob_Vi_ok(rob_Vi_ok), .rob_Vj_ok(rob_Vj_ok),
    .rob_Vi(rob_Vi), .rob_Vj(rob_Vj), .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_data(cdb_data),
    .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
    .out_alias(out_alias), .out_type(out_type), .out_rd(out_rd), .out_pc(out_pc), .out_imm(out_imm),
    .out_Vi(out_Vi), .out_Vj(out_Vj), .out_Qi(out_Qi), .out_Qj(out_Qj),
    .out_is_ls(out_is_ls), .out_is_btype(out_is_btype), .out_pred_jump(out_pred_jump),
    .ren_valid(ren_valid), .ren_reg(ren_reg), .ren_alias(ren_alias)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_ls;
    logic        is_b;
    logic        pj;
  } ent_t;

  ent_t mq[$];
  logic [162:0] e_pay;
  logic [3:0]   e_strb;
  logic [162:0] obs_pay;
  logic [3:0]   obs_strb;
  int checks = 0;
  int errors = 0;

  assign obs_pay  = {out_alias, out_type, out_rd, out_pc, out_imm, out_Vi, out_Vj, out_Qi, out_Qj,
                     out_is_ls, out_is_btype, out_pred_jump, ren_reg, ren_alias};
  assign obs_strb = {rob_issue, rs_issue, lsb_issue, ren_valid};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand value/tag straight from the resolution priority rules.
  function automatic logic [35:0] resolve(input logic [3:0] q, input logic [31:0] v,
                                          input logic ok, input logic [31:0] rv);
    logic [35:0] r;
    logic found;
    found = 1'b0;
    r = {v, q};
    if (q == 4'd0) begin
      r = {v, 4'd0};
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (!found && cdb_valid[k] && cdb_alias[k*ROB_W +: ROB_W] == q) begin
          r = {cdb_data[k*XLEN +: XLEN], 4'd0};
          found = 1'b1;
        end
      end
      if (!found && ok) r = {rv, 4'd0};
    end
    return r;
  endfunction

  task automatic cycle(input string tag);
    ent_t pe, h;
    logic push, iss;
    logic [35:0] ri, rj;
    chk({tag, ":in_ready"}, in_ready, mq.size() != DEPTH);
    chk({tag, ":qfwd"}, {Qi_to_rob, Qj_to_rob}, {rf_Qi, rf_Qj});
    h = '0;
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, ":rs_to_rf"}, {rs1_to_rf, rs2_to_rf}, {h.rs1, h.rs2});
    end
    pe = {in_pc, in_imm, in_type, in_rd, in_rs1, in_rs2, in_is_ls, in_is_btype, in_pred_jump};
    push = in_valid && (mq.size() != DEPTH) && rdy && !rollback;
    iss  = (mq.size() != 0) && rdy && !rollback && !rob_full && (h.is_ls ? !lsb_full : !rs_full);
    if (rdy) begin
      if (iss) begin
        ri = resolve(rf_Qi, rf_Vi, rob_Vi_ok, rob_Vi);
        rj = resolve(rf_Qj, rf_Vj, rob_Vj_ok, rob_Vj);
        e_strb = {1'b1, !h.is_ls, h.is_ls, h.rd != 5'd0};
        e_pay  = {rob_alias, h.typ, h.rd, h.pc, h.imm, ri[35:4], rj[35:4], ri[3:0], rj[3:0],
                  h.is_ls, h.is_b, h.pj, h.rd, rob_alias};
      end else begin
        e_strb = '0;
      end
    end
    @(posedge clk);
    #1;
    if (rdy) begin
      if (rollback) mq.delete();
      else begin
        if (iss) void'(mq.pop_front());
        if (push) mq.push_back(pe);
      end
    end
    chk({tag, ":strb"}, obs_strb, e_strb);
    chk({tag, ":pay"}, obs_pay, e_pay);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [5:0] ty, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic ls, input logic b, input logic pj);
    in_valid = v; in_pc = pc; in_imm = imm; in_type = ty; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_is_ls = ls; in_is_btype = b; in_pred_jump = pj;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rdy = 1; rollback = 0; rob_full = 0; rs_full = 0; lsb_full = 0; rob_alias = 4'd9;
    rf_Vi = 0; rf_Vj = 0; rf_Qi = 0; rf_Qj = 0; rob_Vi_ok = 0; rob_Vj_ok = 0;
    rob_Vi = 0; rob_Vj = 0; cdb_valid = 0; cdb_alias = 0; cdb_data = 0;
  endtask

  // Called 1 time unit after a rising edge; the pulse lands between edges.
  task automatic reset_async(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ":strb"}, obs_strb, 4'd0);
    chk({tag, ":pay"}, obs_pay, 163'd0);
    chk({tag, ":in_ready"}, in_ready, 1'b1);
    mq.delete();
    e_pay = '0;
    e_strb = '0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    e_pay = '0;
    e_strb = '0;
    #3;
    chk("reset:strb", obs_strb, 4'd0);
    chk("reset:pay", obs_pay, 163'd0);
    chk("reset:in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: simple addi through the RS path
    set_in(1, 32'h100, 32'd7, 6'h13, 5'd5, 5'd0, 5'd0, 0, 0, 0);
    cycle("t1_push");
    in_valid = 0;
    cycle("t1_issue");
    chk("t1_rs_issue", {rob_issue, rs_issue, lsb_issue}, 3'b110);
    chk("t1_Vi_Qi", {out_Vi, out_Qi}, 36'd0);
    chk("t1_ren", {ren_reg, ren_alias, out_imm}, {5'd5, 4'd9, 32'd7});

    // 2: CDB priority, then unresolved tag
    set_in(1, 32'h104, 32'd1, 6'h33, 5'd6, 5'd7, 5'd8, 0, 0, 0);
    cycle("t2_push");
    in_valid = 0; rf_Qi = 4'd3; cdb_valid = 2'b11;
    cdb_alias = {4'd3, 4'd3}; cdb_data = {32'hBB, 32'hAA};
    cycle("t2_cdb");
    chk("t2_cdb_win", {out_Vi, out_Qi}, {32'hAA, 4'd0});
    set_in(1, 32'h108, 32'd2, 6'h33, 5'd6, 5'd7, 5'd8, 0, 0, 0);
    cdb_valid = 2'b00; rf_Vi = 32'h55;
    cycle("t2_push2");
    in_valid = 0;
    cycle("t2_nomatch");
    chk("t2_tag", {out_Vi, out_Qi}, {32'h55, 4'd3});
    idle();

    // 3: fill while ROB is full, then drain in order
    rob_full = 1;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h200 + 32'(4 * i), 32'(i), 6'h13, 5'(i + 1), 5'd1, 5'd2, 0, 0, 0);
      cycle("t3_fill");
    end
    chk("t3_full", in_ready, 1'b0);
    rob_full = 0; in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("t3_drain");
      chk("t3_order", {rob_issue, out_pc}, {1'b1, 32'h200 + 32'(4 * i)});
    end
    chk("t3_ready", in_ready, 1'b1);

    // 4: load blocked by LSB only
    set_in(1, 32'h300, 32'd4, 6'h03, 5'd10, 5'd2, 5'd0, 1, 0, 0);
    lsb_full = 1;
    cycle("t4_push");
    in_valid = 0;
    cycle("t4_block");
    cycle("t4_block");
    chk("t4_held", {rob_issue, lsb_issue}, 2'b00);
    lsb_full = 0;
    cycle("t4_go");
    chk("t4_lsb", {lsb_issue, rs_issue}, 2'b10);

    // 5: rollback with a concurrent push
    rob_full = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h400 + 32'(4 * i), 0, 6'h13, 5'd3, 0, 0, 0, 0, 0);
      cycle("t5_fill");
    end
    set_in(1, 32'h4F0, 0, 6'h13, 5'd3, 0, 0, 0, 0, 0);
    rollback = 1;
    cycle("t5_rb");
    chk("t5_rb_state", {obs_strb, in_ready}, 5'b00001);
    rollback = 0; in_valid = 0; rob_full = 0;
    cycle("t5_empty");
    cycle("t5_empty");
    chk("t5_no_issue", rob_issue, 1'b0);

    // 6: rdy stall mid-stream, then async reset mid-stream
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h500 + 32'(4 * i), 32'(i), 6'h13, 5'(i), 5'(i), 5'(31 - i), i[0], 0, i[1]);
      rdy = !(i >= 3 && i < 6);
      rf_Qj = 4'(i);
      cycle("t6_stream");
    end
    rdy = 1;
    reset_async("t6_rst");
    idle();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 9) < 6, $urandom, $urandom, 6'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      rdy       = $urandom_range(0, 9) != 0;
      rollback  = $urandom_range(0, 39) == 0;
      rob_full  = $urandom_range(0, 4) == 0;
      rs_full   = $urandom_range(0, 3) == 0;
      lsb_full  = $urandom_range(0, 3) == 0;
      rob_alias = 4'($urandom);
      rf_Vi = $urandom; rf_Vj = $urandom; rob_Vi = $urandom; rob_Vj = $urandom;
      rf_Qi = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      rf_Qj = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      rob_Vi_ok = 1'($urandom); rob_Vj_ok = 1'($urandom);
      cdb_valid = 2'($urandom);
      cdb_alias = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      cdb_data  = {$urandom, $urandom};
      cycle("rnd");
      if ($urandom_range(0, 199) == 0) reset_async("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
